// File: rtl/hdmi_timing_monitor.sv
// hdmi_timing_monitor
//   Receive-side checker for a parallel HDMI TX pixel bus. Samples the syncs,
//   data enable and pixel data on the pixel clock. It measures the frame
//   geometry and declares lock once the format has matched the expected
//   timing for LOCK_FRAMES frames in a row.
//
//   Optional feature: define FRAME_CRC_EN to build a CRC-16-CCITT over the
//   active pixels of each frame. Without it, frame_crc is tied to zero.
//
// Ports
//   clock        in   pixel clock (single domain)
//   reset_n      in   asynchronous active-low reset
//   h_sync       in   horizontal sync
//   v_sync       in   vertical sync
//   data_enable  in   active-video qualifier
//   rgb_channel  in   24-bit pixel {R,G,B}
//   clear_err    in   synchronous clear of err_sticky
//   h_total      out  measured clocks per line
//   h_active     out  DE clocks on the last active line
//   v_total      out  measured lines per frame
//   v_active     out  measured active lines per frame
//   meas_valid   out  one-cycle pulse when the measurement outputs update
//   locked       out  format matched for LOCK_FRAMES consecutive frames
//   err_sticky   out  set on any mismatch or timeout
//   frame_crc    out  CRC of the active pixels of the last frame
module hdmi_timing_monitor #(
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int H_TOTAL_EXP     = 800,
  parameter int H_ACTIVE_EXP    = 640,
  parameter int V_TOTAL_EXP     = 525,
  parameter int V_ACTIVE_EXP    = 480,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        data_enable,
  input  logic [23:0] rgb_channel,
  input  logic        clear_err,
  output logic [11:0] h_total,
  output logic [11:0] h_active,
  output logic [11:0] v_total,
  output logic [11:0] v_active,
  output logic        meas_valid,
  output logic        locked,
  output logic        err_sticky,
  output logic [15:0] frame_crc
);

  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic        SYNC_IDLE  = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [11:0] H_TOTAL_C  = 12'(H_TOTAL_EXP);
  localparam logic [11:0] H_ACTIVE_C = 12'(H_ACTIVE_EXP);
  localparam logic [11:0] V_TOTAL_C  = 12'(V_TOTAL_EXP);
  localparam logic [11:0] V_ACTIVE_C = 12'(V_ACTIVE_EXP);
  localparam logic [3:0]  LOCK_C     = 4'(LOCK_FRAMES);

  // Saturating 12-bit add: measurement counters stick at 4095
  function automatic logic [11:0] sat_add(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[12] ? 12'hFFF : sum[11:0];
  endfunction

  logic hs_r, vs_r, de_r, clr_r, hs_d_r, vs_d_r;
  logic hs_edge_s, vs_edge_s, timeout_s;
  logic [11:0] h_cnt_r, de_cnt_r, v_cnt_r, va_cnt_r, last_len_r, last_de_r, ref_de_r;
  logic ref_valid_r, h_bad_r, d_bad_r;
  logic [11:0] line_len_s, line_de_s, v_tot_s, v_act_s, h_tot_s, h_act_s;
  logic line_act_s, line_hbad_s, line_dbad_s, frame_ok_s;
  state_t state_r, state_nxt;
  logic [3:0] match_r, match_nxt;
  logic locked_r, locked_nxt, err_r, err_set_s, mv_nxt;
  logic [11:0] h_total_r, h_active_r, v_total_r, v_active_r;

  // Input stage: register the pins once and keep a delayed copy for edge detect
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hs_r   <= SYNC_IDLE;
      vs_r   <= SYNC_IDLE;
      hs_d_r <= SYNC_IDLE;
      vs_d_r <= SYNC_IDLE;
      de_r   <= 1'b0;
      clr_r  <= 1'b0;
    end else begin
      hs_r   <= h_sync;
      vs_r   <= v_sync;
      hs_d_r <= hs_r;
      vs_d_r <= vs_r;
      de_r   <= data_enable;
      clr_r  <= clear_err;
    end
  end

  assign hs_edge_s = (hs_d_r == SYNC_IDLE) && (hs_r != SYNC_IDLE);
  assign vs_edge_s = (vs_d_r == SYNC_IDLE) && (vs_r != SYNC_IDLE);
  // Fires once, on the cycle h_cnt steps onto its saturation value
  assign timeout_s = (h_cnt_r == 12'd4094) && !hs_edge_s;

  // Per-cycle view of the line/frame totals, including the current cycle's edge
  always_comb begin
    line_len_s  = sat_add(h_cnt_r, 12'd1);
    line_de_s   = sat_add(de_cnt_r, {11'd0, de_r});
    line_act_s  = hs_edge_s && (line_de_s != 12'd0);
    line_hbad_s = hs_edge_s && (line_len_s != H_TOTAL_C);
    line_dbad_s = line_act_s && ref_valid_r && (line_de_s != ref_de_r);
    v_tot_s     = sat_add(v_cnt_r, {11'd0, hs_edge_s});
    v_act_s     = sat_add(va_cnt_r, {11'd0, line_act_s});
    if (hs_edge_s) begin
      h_tot_s = line_len_s;
    end else begin
      h_tot_s = last_len_r;
    end
    if (line_act_s) begin
      h_act_s = line_de_s;
    end else begin
      h_act_s = last_de_r;
    end
    frame_ok_s = !(h_bad_r || line_hbad_s || d_bad_r || line_dbad_s) &&
                 (h_tot_s == H_TOTAL_C) && (h_act_s == H_ACTIVE_C) &&
                 (v_tot_s == V_TOTAL_C) && (v_act_s == V_ACTIVE_C);
  end

  // Line and frame measurement counters; frame accumulators restart at each vsync edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_r     <= 12'd0;
      de_cnt_r    <= 12'd0;
      v_cnt_r     <= 12'd0;
      va_cnt_r    <= 12'd0;
      last_len_r  <= 12'd0;
      last_de_r   <= 12'd0;
      ref_de_r    <= 12'd0;
      ref_valid_r <= 1'b0;
      h_bad_r     <= 1'b0;
      d_bad_r     <= 1'b0;
    end else begin
      h_cnt_r  <= hs_edge_s ? 12'd0 : line_len_s;
      de_cnt_r <= hs_edge_s ? 12'd0 : line_de_s;
      if (hs_edge_s) last_len_r <= line_len_s;
      if (line_act_s) last_de_r <= line_de_s;
      if (vs_edge_s) begin
        v_cnt_r     <= 12'd0;
        va_cnt_r    <= 12'd0;
        h_bad_r     <= 1'b0;
        d_bad_r     <= 1'b0;
        ref_valid_r <= 1'b0;
      end else begin
        v_cnt_r  <= v_tot_s;
        va_cnt_r <= v_act_s;
        h_bad_r  <= h_bad_r || line_hbad_s;
        d_bad_r  <= d_bad_r || line_dbad_s;
        if (line_act_s && !ref_valid_r) begin
          ref_de_r    <= line_de_s;
          ref_valid_r <= 1'b1;
        end
      end
    end
  end

  // Lock FSM next-state and output decisions; timeout overrides everything
  always_comb begin
    state_nxt  = state_r;
    match_nxt  = match_r;
    locked_nxt = locked_r;
    err_set_s  = 1'b0;
    mv_nxt     = 1'b0;
    if (timeout_s) begin
      state_nxt  = SEARCH;
      match_nxt  = 4'd0;
      locked_nxt = 1'b0;
      err_set_s  = 1'b1;
    end else if (vs_edge_s) begin
      case (state_r)
        SEARCH: begin
          state_nxt = MEASURE;
          match_nxt = 4'd0;
        end
        MEASURE: begin
          mv_nxt = 1'b1;
          if (frame_ok_s) begin
            match_nxt = match_r + 4'd1;
            if ((match_r + 4'd1) >= LOCK_C) begin
              state_nxt  = LOCKED;
              locked_nxt = 1'b1;
            end else begin
              state_nxt = MEASURE;
            end
          end else begin
            match_nxt = 4'd0;
            err_set_s = 1'b1;
          end
        end
        LOCKED: begin
          mv_nxt = 1'b1;
          if (frame_ok_s) begin
            state_nxt = LOCKED;
          end else begin
            state_nxt  = MEASURE;
            match_nxt  = 4'd0;
            locked_nxt = 1'b0;
            err_set_s  = 1'b1;
          end
        end
        default: begin
          state_nxt  = SEARCH;
          match_nxt  = 4'd0;
          locked_nxt = 1'b0;
        end
      endcase
    end else begin
      mv_nxt = 1'b0;
    end
  end

  // FSM state and registered outputs; an error set wins over clear_err
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= SEARCH;
      match_r    <= 4'd0;
      locked_r   <= 1'b0;
      err_r      <= 1'b0;
      meas_valid <= 1'b0;
      h_total_r  <= 12'd0;
      h_active_r <= 12'd0;
      v_total_r  <= 12'd0;
      v_active_r <= 12'd0;
    end else begin
      state_r    <= state_nxt;
      match_r    <= match_nxt;
      locked_r   <= locked_nxt;
      err_r      <= err_set_s ? 1'b1 : (clr_r ? 1'b0 : err_r);
      meas_valid <= mv_nxt;
      if (mv_nxt) begin
        h_total_r  <= h_tot_s;
        h_active_r <= h_act_s;
        v_total_r  <= v_tot_s;
        v_active_r <= v_act_s;
      end
    end
  end

  assign h_total    = h_total_r;
  assign h_active   = h_active_r;
  assign v_total    = v_total_r;
  assign v_active   = v_active_r;
  assign locked     = locked_r;
  assign err_sticky = err_r;

`ifdef FRAME_CRC_EN
  logic [23:0] rgb_r;
  logic [15:0] crc_r, crc_cur_s, frame_crc_r;

  // CRC-16-CCITT (poly 0x1021), 24 data bits MSB first, no reflection
  function automatic logic [15:0] crc16_step(input logic [15:0] crc_in, input logic [23:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 23; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // Fold the current pixel into the running CRC when DE is high
  always_comb begin
    if (de_r) begin
      crc_cur_s = crc16_step(crc_r, rgb_r);
    end else begin
      crc_cur_s = crc_r;
    end
  end

  // Pixel register, running CRC (restarted at vsync edge) and latched result
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rgb_r       <= 24'h000000;
      crc_r       <= 16'hFFFF;
      frame_crc_r <= 16'h0000;
    end else begin
      rgb_r <= rgb_channel;
      crc_r <= vs_edge_s ? 16'hFFFF : crc_cur_s;
      if (mv_nxt) frame_crc_r <= crc_cur_s;
    end
  end

  assign frame_crc = frame_crc_r;
`else
  logic unused_s;
  assign unused_s  = ^rgb_channel;
  assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_hdmi_timing_monitor.sv
// Directed bench for hdmi_timing_monitor. Uses a scaled-down raster
// (40x20 total, 24x12 active) so the whole run stays short; the
// timeout threshold (4095 clocks) is independent of the raster size.
module tb_hdmi_timing_monitor;

  localparam int HT = 40, HA = 24, HS0 = 28, HS1 = 34;
  localparam int VT = 20, VA = 12, VS0 = 14, VS1 = 16;

  logic        clock = 1'b0;
  logic        reset_n, h_sync, v_sync, data_enable, clear_err;
  logic [23:0] rgb_channel;
  logic [11:0] h_total, h_active, v_total, v_active;
  logic        meas_valid, locked, err_sticky;
  logic [15:0] frame_crc;

  int pass_cnt = 0, chk_cnt = 0, fail_cnt = 0;
  int hpos = 0, vpos = 0, long_v = -1, short_v = -1;
  int mv_cnt = 0, mv_h = -1, mv_v = -1;
  logic [11:0] s_ht, s_ha, s_vt, s_va;
  logic [15:0] s_crc, exp_crc;

  hdmi_timing_monitor #(
    .SYNC_ACTIVE_LOW(1), .H_TOTAL_EXP(HT), .H_ACTIVE_EXP(HA),
    .V_TOTAL_EXP(VT), .V_ACTIVE_EXP(VA), .LOCK_FRAMES(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .h_sync(h_sync), .v_sync(v_sync),
    .data_enable(data_enable), .rgb_channel(rgb_channel), .clear_err(clear_err),
    .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
    .meas_valid(meas_valid), .locked(locked), .err_sticky(err_sticky),
    .frame_crc(frame_crc)
  );

  always #5 clock = ~clock;

`ifdef FRAME_CRC_EN
  // Reference CRC-16-CCITT over one frame of constant 24'hFF0000 pixels
  function automatic logic [15:0] crc_model(input int npix);
    logic [15:0] c;
    logic [23:0] px;
    c  = 16'hFFFF;
    px = 24'hFF0000;
    for (int p = 0; p < npix; p++) begin
      for (int b = 23; b >= 0; b--) begin
        if (c[15] ^ px[b]) c = (c << 1) ^ 16'h1021;
        else               c = c << 1;
      end
    end
    return c;
  endfunction
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pixel clock: drive raster (or idle) inputs, sample after the edge
  task automatic tick(input bit idle);
    if (idle) begin
      h_sync = 1'b1; v_sync = 1'b1; data_enable = 1'b0; rgb_channel = 24'h000000;
    end else begin
      h_sync      = !(hpos >= HS0 && hpos < HS1);
      v_sync      = !(vpos >= VS0 && vpos < VS1);
      data_enable = (vpos < VA) && (hpos < ((vpos == short_v) ? HA - 1 : HA));
      rgb_channel = data_enable ? 24'hFF0000 : 24'h000000;
    end
    @(posedge clock);
    #1;
    if (meas_valid === 1'b1) begin
      mv_cnt++; mv_h = hpos; mv_v = vpos;
      s_ht = h_total; s_ha = h_active; s_vt = v_total; s_va = v_active; s_crc = frame_crc;
    end
    if (!idle) begin
      hpos++;
      if (hpos >= ((vpos == long_v) ? HT + 1 : HT)) begin
        hpos = 0;
        vpos = (vpos == VT - 1) ? 0 : vpos + 1;
      end
    end
  endtask

  task automatic run_frame();
    do tick(1'b0); while (!(hpos == 0 && vpos == 0));
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1; tick(1'b0); clear_err = 1'b0; tick(1'b0); tick(1'b0);
  endtask

  initial begin
`ifdef FRAME_CRC_EN
    exp_crc = crc_model(HA * VA);
`else
    exp_crc = 16'h0000;
`endif
    reset_n = 1'b0; clear_err = 1'b0;
    h_sync = 1'b1; v_sync = 1'b1; data_enable = 1'b0; rgb_channel = 24'h000000;
    repeat (3) @(posedge clock);
    #1;
    check("rst_h_total", h_total, 0);     check("rst_h_active", h_active, 0);
    check("rst_v_total", v_total, 0);     check("rst_v_active", v_active, 0);
    check("rst_meas_valid", meas_valid, 0); check("rst_locked", locked, 0);
    check("rst_err", err_sticky, 0);      check("rst_crc", frame_crc, 0);
    reset_n = 1'b1;

    // Nominal frames: first vsync edge only arms the measurement
    run_frame();
    check("t1_f1_no_mv", mv_cnt, 0);      check("t1_f1_locked", locked, 0);
    run_frame();
    check("t1_f2_mv", mv_cnt, 1);
    check("t1_mv_hpos", mv_h, 1);         check("t1_mv_vpos", mv_v, VS0);
    check("t1_h_total", s_ht, HT);        check("t1_h_active", s_ha, HA);
    check("t1_v_total", s_vt, VT);        check("t1_v_active", s_va, VA);
    check("t1_f2_locked", locked, 0);     check("t1_crc", s_crc, exp_crc);
    run_frame();
    check("t1_f3_mv", mv_cnt, 2);         check("t1_f3_locked", locked, 1);
    run_frame();
    check("t1_f4_mv", mv_cnt, 3);         check("t1_f4_locked", locked, 1);
    check("t1_f4_err", err_sticky, 0);

    // One line one clock too long
    long_v = 3; run_frame(); long_v = -1;
    check("t2_mv", mv_cnt, 4);            check("t2_locked", locked, 0);
    check("t2_err", err_sticky, 1);       check("t2_h_total_last", s_ht, HT);
    pulse_clear();
    check("t2_err_cleared", err_sticky, 0);
    run_frame();
    check("t2_relock1_locked", locked, 0);
    run_frame();
    check("t2_relock2_locked", locked, 1); check("t2_relock_err", err_sticky, 0);

    // One active line with one DE clock missing
    short_v = 5; run_frame(); short_v = -1;
    check("t5_mv", mv_cnt, 7);            check("t5_err", err_sticky, 1);
    check("t5_locked", locked, 0);        check("t5_h_active", s_ha, HA);
    check("t5_v_active", s_va, VA);

    // Relock, then starve h_sync into a timeout
    pulse_clear(); run_frame(); run_frame();
    check("t3_pre_locked", locked, 1);    check("t3_pre_err", err_sticky, 0);
    repeat (3000) tick(1'b1);
    check("t3_mid_locked", locked, 1);    check("t3_mid_err", err_sticky, 0);
    repeat (2000) tick(1'b1);
    check("t3_to_locked", locked, 0);     check("t3_to_err", err_sticky, 1);
    check("t3_to_no_mv", mv_cnt, 9);
    run_frame();
    check("t3_search_no_mv", mv_cnt, 9);
    run_frame();
    check("t3_remeasure_mv", mv_cnt, 10); check("t3_remeasure_h_total", s_ht, HT);

    // Reset mid-frame
    repeat (6 * HT) tick(1'b0);
    reset_n = 1'b0;
    #1;
    check("t4_h_total", h_total, 0);      check("t4_v_total", v_total, 0);
    check("t4_h_active", h_active, 0);    check("t4_v_active", v_active, 0);
    check("t4_err", err_sticky, 0);       check("t4_meas_valid", meas_valid, 0);
    check("t4_crc", frame_crc, 0);
    repeat (3) tick(1'b0);
    reset_n = 1'b1;
    run_frame();
    check("t4_first_edge_no_mv", mv_cnt, 10);
    run_frame();
    check("t4_second_edge_mv", mv_cnt, 11); check("t4_mv_hpos", mv_h, 1);
    check("t4_v_total_meas", s_vt, VT);   check("t4_locked", locked, 0);
    check("t6_crc", s_crc, exp_crc);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
